muldiv_ctrl: RTL and testbench

MULDIV_CTRL -- requirements
Module: muldiv_ctrl

---
 rtl/muldiv_ctrl.sv | 177 +++++++++++++++++
 tb/tb_muldiv_ctrl.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/muldiv_ctrl.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer owning the architectural HI/LO registers.
// Results are computed at issue and held pending until the busy window expires.
module muldiv_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        cancel,
  input  logic [2:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        done
);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  localparam logic [3:0] CNT_MULT = 4'(MULT_CYCLES);
  localparam logic [3:0] CNT_DIV  = 4'(DIV_CYCLES);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] pend_hi_q, pend_hi_d;
  logic [31:0] pend_lo_q, pend_lo_d;
  logic        pend_wr_q, pend_wr_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        done_q, done_d;

  logic        issue;
  logic        is_mul;
  logic        is_div;
  logic        finish;
  logic [63:0] mul_res;
  logic [63:0] div_res;

  function automatic logic [63:0] mul_full(input logic [31:0] a, input logic [31:0] b,
                                           input logic sgn);
    logic signed [63:0] sa;
    logic signed [63:0] sb;
    logic [63:0]        p;
    if (sgn) begin
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
      p  = sa * sb;
    end else begin
      p = {32'd0, a} * {32'd0, b};
    end
    return p;
  endfunction

  // Returns {remainder, quotient}; magnitudes are divided unsigned and signs restored,
  // which also yields 0x80000000 / -1 = 0x80000000 rem 0 without a special case.
  function automatic logic [63:0] div_full(input logic [31:0] a, input logic [31:0] b,
                                           input logic sgn);
    logic [31:0] ua;
    logic [31:0] ub;
    logic [31:0] q;
    logic [31:0] r;
    logic        neg_q;
    logic        neg_r;
    neg_q = sgn & (a[31] ^ b[31]);
    neg_r = sgn & a[31];
    ua    = (sgn && a[31]) ? -a : a;
    ub    = (sgn && b[31]) ? -b : b;
    if (ub == 32'd0) begin
      ub = 32'd1;
    end
    q = ua / ub;
    r = ua % ub;
    if (neg_q) begin
      q = -q;
    end
    if (neg_r) begin
      r = -r;
    end
    return {r, q};
  endfunction

  assign issue   = (state_q == IDLE) && start && !cancel;
  assign is_mul  = (op == OP_MULT) || (op == OP_MULTU);
  assign is_div  = (op == OP_DIV) || (op == OP_DIVU);
  assign finish  = (state_q == RUN) && (cnt_q <= 4'd1);
  assign mul_res = mul_full(rs_val, rt_val, op == OP_MULT);
  assign div_res = div_full(rs_val, rt_val, op == OP_DIV);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      pend_hi_q <= 32'd0;
      pend_lo_q <= 32'd0;
      pend_wr_q <= 1'b0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      pend_wr_q <= pend_wr_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (issue && (is_mul || is_div)) state_d = RUN;
      RUN:     if (finish) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d     = cnt_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    pend_wr_d = pend_wr_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    if (issue) begin
      case (op)
        OP_MULT, OP_MULTU: begin
          cnt_d     = CNT_MULT;
          pend_hi_d = mul_res[63:32];
          pend_lo_d = mul_res[31:0];
          pend_wr_d = 1'b1;
        end
        OP_DIV, OP_DIVU: begin
          cnt_d     = CNT_DIV;
          pend_hi_d = div_res[63:32];
          pend_lo_d = div_res[31:0];
          // A zero divisor still burns the full busy window but leaves HI/LO alone.
          pend_wr_d = (rt_val != 32'd0);
        end
        OP_MTHI: hi_d = rs_val;
        OP_MTLO: lo_d = rs_val;
        default: ;
      endcase
    end else if (state_q == RUN) begin
      if (finish) begin
        cnt_d  = 4'd0;
        done_d = 1'b1;
        if (pend_wr_q) begin
          hi_d = pend_hi_q;
          lo_d = pend_lo_q;
        end
      end else begin
        cnt_d = cnt_q - 4'd1;
      end
    end
  end

  always_comb begin
    busy = (state_q == RUN);
    hi   = hi_q;
    lo   = lo_q;
    done = done_q;
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl: busy window length, done timing, HI/LO results,
// ignored/cancelled starts and asynchronous reset in mid-operation.
module tb_muldiv_ctrl;

  logic        clk;
  logic        reset;
  logic        start;
  logic        cancel;
  logic [2:0]  op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        done;

  int total;
  int bad;

  muldiv_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .cancel (cancel),
    .op     (op),
    .rs_val (rs_val),
    .rt_val (rt_val),
    .busy   (busy),
    .hi     (hi),
    .lo     (lo),
    .done   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one mult/div and watches a fixed window after the issue edge.
  // Sample k=1 is the first cycle after issue.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input int n, input logic [31:0] eh,
                        input logic [31:0] el, input bit cancel_mid);
    int bcnt, blast, dat, dcnt;
    logic [31:0] hi0, lo0, hin, lon;
    hi0 = hi;
    lo0 = lo;
    hin = 32'hx;
    lon = 32'hx;
    op = o; rs_val = a; rt_val = b; start = 1'b1;
    tick();
    start = 1'b0;
    if (cancel_mid) cancel = 1'b1;
    bcnt = 0; blast = 0; dat = 0; dcnt = 0;
    for (int k = 1; k <= n + 4; k++) begin
      if (busy === 1'b1) begin
        bcnt++;
        blast = k;
      end
      if (done === 1'b1) begin
        dcnt++;
        if (dat == 0) dat = k;
      end
      if (k == n) begin
        hin = hi;
        lon = lo;
      end
      tick();
    end
    cancel = 1'b0;
    chk({tag, "_busy_cycles"}, 32'(bcnt), 32'(n));
    chk({tag, "_busy_last"}, 32'(blast), 32'(n));
    chk({tag, "_done_cycle"}, 32'(dat), 32'(n + 1));
    chk({tag, "_done_count"}, 32'(dcnt), 32'd1);
    chk({tag, "_hi_held"}, hin, hi0);
    chk({tag, "_lo_held"}, lon, lo0);
    chk({tag, "_hi"}, hi, eh);
    chk({tag, "_lo"}, lo, el);
  endtask

  initial begin
    int dcnt, bcnt;
    total = 0;
    bad   = 0;
    reset = 1'b1; start = 1'b0; cancel = 1'b0; op = 3'd0; rs_val = 32'd0; rt_val = 32'd0;
    tick();
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    reset = 1'b0;
    tick();

    run_op("mult",   3'd0, 32'hFFFFFFFF, 32'd2, 5, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0);
    run_op("multu",  3'd1, 32'hFFFFFFFF, 32'd2, 5, 32'h00000001, 32'hFFFFFFFE, 1'b0);
    run_op("div",    3'd2, 32'hFFFFFFF9, 32'd2, 10, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
    run_op("divu",   3'd3, 32'd7, 32'd2, 10, 32'd1, 32'd3, 1'b0);
    run_op("div_ovf", 3'd2, 32'h80000000, 32'hFFFFFFFF, 10, 32'd0, 32'h80000000, 1'b0);

    op = 3'd5; rs_val = 32'h12345678; start = 1'b1;
    tick();
    start = 1'b0;
    chk("mtlo_lo", lo, 32'h12345678);
    chk("mtlo_hi", hi, 32'd0);
    chk("mtlo_busy", {31'd0, busy}, 32'd0);
    tick();
    chk("mtlo_done", {31'd0, done}, 32'd0);

    run_op("divu_zero", 3'd3, 32'd99, 32'd0, 10, 32'd0, 32'h12345678, 1'b0);

    op = 3'd4; rs_val = 32'hAABBCCDD; start = 1'b1;
    tick();
    start = 1'b0;
    chk("mthi_hi", hi, 32'hAABBCCDD);
    chk("mthi_busy", {31'd0, busy}, 32'd0);

    op = 3'd6; rs_val = 32'h0BAD0BAD; rt_val = 32'd3; start = 1'b1;
    tick();
    op = 3'd7;
    tick();
    start = 1'b0;
    chk("nop_busy", {31'd0, busy}, 32'd0);
    chk("nop_hi", hi, 32'hAABBCCDD);
    chk("nop_lo", lo, 32'h12345678);

    // MULT 3 * -4, then an MTHI attempt during busy cycle 2.
    op = 3'd0; rs_val = 32'd3; rt_val = 32'hFFFFFFFC; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    op = 3'd4; rs_val = 32'h55555555; start = 1'b1;
    tick();
    start = 1'b0;
    chk("run_start_hi", hi, 32'hAABBCCDD);
    chk("run_start_busy", {31'd0, busy}, 32'd1);
    for (int k = 0; k < 8; k++) tick();
    chk("run_start_busy_end", {31'd0, busy}, 32'd0);
    chk("run_start_res_hi", hi, 32'hFFFFFFFF);
    chk("run_start_res_lo", lo, 32'hFFFFFFF4);

    op = 3'd2; rs_val = 32'd100; rt_val = 32'd3; start = 1'b1; cancel = 1'b1;
    tick();
    chk("cancel_busy1", {31'd0, busy}, 32'd0);
    start = 1'b0; cancel = 1'b0;
    tick();
    chk("cancel_busy2", {31'd0, busy}, 32'd0);
    chk("cancel_done", {31'd0, done}, 32'd0);
    chk("cancel_hi", hi, 32'hFFFFFFFF);
    chk("cancel_lo", lo, 32'hFFFFFFF4);

    run_op("cancel_mid", 3'd1, 32'd6, 32'd7, 5, 32'd0, 32'd42, 1'b1);

    // DIV 100/7, reset asserted in the middle of busy cycle 4.
    op = 3'd2; rs_val = 32'd100; rt_val = 32'd7; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    chk("rstmid_busy_pre", {31'd0, busy}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("rstmid_busy", {31'd0, busy}, 32'd0);
    chk("rstmid_hi", hi, 32'd0);
    chk("rstmid_lo", lo, 32'd0);
    tick();
    reset = 1'b0;
    dcnt = 0;
    bcnt = 0;
    for (int k = 0; k < 15; k++) begin
      if (done === 1'b1) dcnt++;
      if (busy === 1'b1) bcnt++;
      tick();
    end
    chk("rstmid_no_done", 32'(dcnt), 32'd0);
    chk("rstmid_no_busy", 32'(bcnt), 32'd0);
    chk("rstmid_hi_after", hi, 32'd0);

    run_op("post_rst", 3'd0, 32'h00010000, 32'h00010000, 5, 32'd1, 32'd0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
